// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU operation encoding, datapath word and the ID/EX control word.
package cpu_types_pkg;

  localparam int unsigned WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [3:0] {
    ALU_SLL  = 4'd0,
    ALU_SRL  = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOR  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_t;

  typedef struct packed {
    logic       RegWEN;
    logic       ALUSrc;
    logic       dmemREN;
    logic       dmemWEN;
    logic       halt;
    logic       branch;
    logic [1:0] tmpPC;
    logic [1:0] RegDest;
    logic [1:0] MemtoReg;
    aluop_t     ALUOP;
  } id_ex_ctrl_t;

  // A bubble issues no writes, no memory access, no branch and falls through sequentially.
  localparam id_ex_ctrl_t ID_EX_BUBBLE = '{
    RegWEN:   1'b0,
    ALUSrc:   1'b0,
    dmemREN:  1'b0,
    dmemWEN:  1'b0,
    halt:     1'b0,
    branch:   1'b0,
    tmpPC:    2'b00,
    RegDest:  2'b00,
    MemtoReg: 2'b00,
    ALUOP:    ALU_SLL
  };

endpackage

// File: rtl/imm_ext.sv
// Combinational immediate extender: sign-extends when sign=1, zero-extends otherwise.
module imm_ext #(
  parameter int unsigned IMM_W  = 16,
  parameter int unsigned WORD_W = 32
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic              sign,
  output logic [WORD_W-1:0] word
);

  always_comb begin
    word = {{(WORD_W-IMM_W){1'b0}}, imm};
    if (sign) begin
      word = {{(WORD_W-IMM_W){imm[IMM_W-1]}}, imm};
    end
  end

endmodule

// File: rtl/id_ex_latch.sv
// Decode-to-execute pipeline register with stall, flush-to-bubble and sticky halt.
// Optional trace ports instr/pc are present when ID_EX_TRACE_EN is defined.
module id_ex_latch
  import cpu_types_pkg::*;
#(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned IMM_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              en,
  input  logic              flush,
  input  logic              RegWEN_i,
  input  logic              ALUSrc_i,
  input  logic              ExtOp_i,
  input  logic              dmemREN_i,
  input  logic              dmemWEN_i,
  input  logic              halt_i,
  input  logic              branch_i,
  input  logic [1:0]        tmpPC_i,
  input  logic [1:0]        RegDest_i,
  input  logic [1:0]        MemtoReg_i,
  input  aluop_t            ALUOP_i,
  input  logic [WORD_W-1:0] rdat1_i,
  input  logic [WORD_W-1:0] rdat2_i,
  input  logic [IMM_W-1:0]  imm_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [4:0]        shamt_i,
  input  logic [WORD_W-1:0] npc_i,
  input  logic [25:0]       jaddr_i,
`ifdef ID_EX_TRACE_EN
  input  logic [WORD_W-1:0] instr_i,
  input  logic [WORD_W-1:0] pc_i,
  output logic [WORD_W-1:0] instr_o,
  output logic [WORD_W-1:0] pc_o,
`endif
  output logic              RegWEN_o,
  output logic              ALUSrc_o,
  output logic              dmemREN_o,
  output logic              dmemWEN_o,
  output logic              halt_o,
  output logic              branch_o,
  output logic [1:0]        tmpPC_o,
  output logic [1:0]        RegDest_o,
  output logic [1:0]        MemtoReg_o,
  output aluop_t            ALUOP_o,
  output logic [WORD_W-1:0] rdat1_o,
  output logic [WORD_W-1:0] rdat2_o,
  output logic [4:0]        rs_o,
  output logic [4:0]        rt_o,
  output logic [4:0]        rd_o,
  output logic [4:0]        shamt_o,
  output logic [WORD_W-1:0] npc_o,
  output logic [25:0]       jaddr_o,
  output logic [WORD_W-1:0] imm32_o,
  output logic              valid_o,
  output logic              halted_o
);

  logic [WORD_W-1:0] imm32;
  id_ex_ctrl_t       ctrl_in;
  id_ex_ctrl_t       ctrl_q;
  logic              capture;

  imm_ext #(
    .IMM_W  (IMM_W),
    .WORD_W (WORD_W)
  ) u_imm_ext (
    .imm  (imm_i),
    .sign (ExtOp_i),
    .word (imm32)
  );

  always_comb begin
    ctrl_in          = ID_EX_BUBBLE;
    ctrl_in.RegWEN   = RegWEN_i;
    ctrl_in.ALUSrc   = ALUSrc_i;
    ctrl_in.dmemREN  = dmemREN_i;
    ctrl_in.dmemWEN  = dmemWEN_i;
    ctrl_in.halt     = halt_i;
    ctrl_in.branch   = branch_i;
    ctrl_in.tmpPC    = tmpPC_i;
    ctrl_in.RegDest  = RegDest_i;
    ctrl_in.MemtoReg = MemtoReg_i;
    ctrl_in.ALUOP    = ALUOP_i;
  end

  // Once halted the slot is frozen; only flush or reset may change it.
  assign capture = en && !halted_o;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ctrl_q   <= ID_EX_BUBBLE;
      rdat1_o  <= '0;
      rdat2_o  <= '0;
      rs_o     <= '0;
      rt_o     <= '0;
      rd_o     <= '0;
      shamt_o  <= '0;
      npc_o    <= '0;
      jaddr_o  <= '0;
      imm32_o  <= '0;
`ifdef ID_EX_TRACE_EN
      instr_o  <= '0;
      pc_o     <= '0;
`endif
      valid_o  <= 1'b0;
      halted_o <= 1'b0;
    end else if (flush) begin
      // halted_o deliberately survives a flush
      ctrl_q   <= ID_EX_BUBBLE;
      rdat1_o  <= '0;
      rdat2_o  <= '0;
      rs_o     <= '0;
      rt_o     <= '0;
      rd_o     <= '0;
      shamt_o  <= '0;
      npc_o    <= '0;
      jaddr_o  <= '0;
      imm32_o  <= '0;
`ifdef ID_EX_TRACE_EN
      instr_o  <= '0;
      pc_o     <= '0;
`endif
      valid_o  <= 1'b0;
    end else if (capture) begin
      ctrl_q   <= ctrl_in;
      rdat1_o  <= rdat1_i;
      rdat2_o  <= rdat2_i;
      rs_o     <= rs_i;
      rt_o     <= rt_i;
      rd_o     <= rd_i;
      shamt_o  <= shamt_i;
      npc_o    <= npc_i;
      jaddr_o  <= jaddr_i;
      imm32_o  <= imm32;
`ifdef ID_EX_TRACE_EN
      instr_o  <= instr_i;
      pc_o     <= pc_i;
`endif
      valid_o  <= 1'b1;
      if (halt_i) begin
        halted_o <= 1'b1;
      end
    end
  end

  assign RegWEN_o   = ctrl_q.RegWEN;
  assign ALUSrc_o   = ctrl_q.ALUSrc;
  assign dmemREN_o  = ctrl_q.dmemREN;
  assign dmemWEN_o  = ctrl_q.dmemWEN;
  assign halt_o     = ctrl_q.halt;
  assign branch_o   = ctrl_q.branch;
  assign tmpPC_o    = ctrl_q.tmpPC;
  assign RegDest_o  = ctrl_q.RegDest;
  assign MemtoReg_o = ctrl_q.MemtoReg;
  assign ALUOP_o    = ctrl_q.ALUOP;

endmodule

// File: tb/tb_id_ex_latch.sv
// Scoreboard bench for id_ex_latch: predicted outputs are queued per edge and checked after it.
module tb_id_ex_latch;
  import cpu_types_pkg::*;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        nRST, en, flush;
  logic        RegWEN_i, ALUSrc_i, ExtOp_i, dmemREN_i, dmemWEN_i, halt_i, branch_i;
  logic [1:0]  tmpPC_i, RegDest_i, MemtoReg_i;
  aluop_t      ALUOP_i;
  logic [31:0] rdat1_i, rdat2_i, npc_i;
  logic [15:0] imm_i;
  logic [4:0]  rs_i, rt_i, rd_i, shamt_i;
  logic [25:0] jaddr_i;

  logic        RegWEN_o, ALUSrc_o, dmemREN_o, dmemWEN_o, halt_o, branch_o;
  logic [1:0]  tmpPC_o, RegDest_o, MemtoReg_o;
  aluop_t      ALUOP_o;
  logic [31:0] rdat1_o, rdat2_o, npc_o, imm32_o;
  logic [4:0]  rs_o, rt_o, rd_o, shamt_o;
  logic [25:0] jaddr_o;
  logic        valid_o, halted_o;
`ifdef ID_EX_TRACE_EN
  logic [31:0] instr_i, pc_i, instr_o, pc_o;
`endif

  id_ex_latch #(.WORD_W(32), .IMM_W(16)) dut (
    .CLK(CLK), .nRST(nRST), .en(en), .flush(flush),
    .RegWEN_i(RegWEN_i), .ALUSrc_i(ALUSrc_i), .ExtOp_i(ExtOp_i), .dmemREN_i(dmemREN_i),
    .dmemWEN_i(dmemWEN_i), .halt_i(halt_i), .branch_i(branch_i), .tmpPC_i(tmpPC_i),
    .RegDest_i(RegDest_i), .MemtoReg_i(MemtoReg_i), .ALUOP_i(ALUOP_i),
    .rdat1_i(rdat1_i), .rdat2_i(rdat2_i), .imm_i(imm_i), .rs_i(rs_i), .rt_i(rt_i),
    .rd_i(rd_i), .shamt_i(shamt_i), .npc_i(npc_i), .jaddr_i(jaddr_i),
`ifdef ID_EX_TRACE_EN
    .instr_i(instr_i), .pc_i(pc_i), .instr_o(instr_o), .pc_o(pc_o),
`endif
    .RegWEN_o(RegWEN_o), .ALUSrc_o(ALUSrc_o), .dmemREN_o(dmemREN_o), .dmemWEN_o(dmemWEN_o),
    .halt_o(halt_o), .branch_o(branch_o), .tmpPC_o(tmpPC_o), .RegDest_o(RegDest_o),
    .MemtoReg_o(MemtoReg_o), .ALUOP_o(ALUOP_o), .rdat1_o(rdat1_o), .rdat2_o(rdat2_o),
    .rs_o(rs_o), .rt_o(rt_o), .rd_o(rd_o), .shamt_o(shamt_o), .npc_o(npc_o),
    .jaddr_o(jaddr_o), .imm32_o(imm32_o), .valid_o(valid_o), .halted_o(halted_o)
  );

  typedef struct packed {
    logic        valid, halted, RegWEN, ALUSrc, dmemREN, dmemWEN, halt, branch;
    logic [1:0]  tmpPC, RegDest, MemtoReg;
    logic [3:0]  ALUOP;
    logic [31:0] rdat1, rdat2, imm32;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] npc;
    logic [25:0] jaddr;
`ifdef ID_EX_TRACE_EN
    logic [31:0] instr, pc;
`endif
  } outs_t;

  outs_t model;
  logic  m_halted;
  outs_t sbq[$];
  int    checks = 0;
  int    failures = 0;

  function automatic outs_t actual();
    outs_t a;
    a.valid = valid_o; a.halted = halted_o; a.RegWEN = RegWEN_o; a.ALUSrc = ALUSrc_o;
    a.dmemREN = dmemREN_o; a.dmemWEN = dmemWEN_o; a.halt = halt_o; a.branch = branch_o;
    a.tmpPC = tmpPC_o; a.RegDest = RegDest_o; a.MemtoReg = MemtoReg_o; a.ALUOP = ALUOP_o;
    a.rdat1 = rdat1_o; a.rdat2 = rdat2_o; a.imm32 = imm32_o; a.rs = rs_o; a.rt = rt_o;
    a.rd = rd_o; a.shamt = shamt_o; a.npc = npc_o; a.jaddr = jaddr_o;
`ifdef ID_EX_TRACE_EN
    a.instr = instr_o; a.pc = pc_o;
`endif
    return a;
  endfunction

  // What the slot should hold after a capture of the current inputs.
  function automatic outs_t captured();
    outs_t c = '0;
    c.valid = 1'b1; c.halted = m_halted | halt_i;
    c.RegWEN = RegWEN_i; c.ALUSrc = ALUSrc_i; c.dmemREN = dmemREN_i; c.dmemWEN = dmemWEN_i;
    c.halt = halt_i; c.branch = branch_i; c.tmpPC = tmpPC_i; c.RegDest = RegDest_i;
    c.MemtoReg = MemtoReg_i; c.ALUOP = ALUOP_i; c.rdat1 = rdat1_i; c.rdat2 = rdat2_i;
    c.imm32 = ExtOp_i ? {{16{imm_i[15]}}, imm_i} : {16'h0000, imm_i};
    c.rs = rs_i; c.rt = rt_i; c.rd = rd_i; c.shamt = shamt_i; c.npc = npc_i; c.jaddr = jaddr_i;
`ifdef ID_EX_TRACE_EN
    c.instr = instr_i; c.pc = pc_i;
`endif
    return c;
  endfunction

  task automatic rand_inputs();
    RegWEN_i = 1'($urandom); ALUSrc_i = 1'($urandom); ExtOp_i = 1'($urandom);
    dmemREN_i = 1'($urandom); dmemWEN_i = 1'($urandom); halt_i = 1'b0; branch_i = 1'($urandom);
    tmpPC_i = 2'($urandom); RegDest_i = 2'($urandom); MemtoReg_i = 2'($urandom);
    ALUOP_i = aluop_t'($urandom_range(0, 9));
    rdat1_i = $urandom; rdat2_i = $urandom; imm_i = 16'($urandom); npc_i = $urandom;
    rs_i = 5'($urandom); rt_i = 5'($urandom); rd_i = 5'($urandom); shamt_i = 5'($urandom);
    jaddr_i = 26'($urandom);
`ifdef ID_EX_TRACE_EN
    instr_i = $urandom; pc_i = $urandom;
`endif
  endtask

  // Predict the post-edge state from current inputs, queue it, then advance one edge.
  task automatic step();
    outs_t e = model;
    if (flush) begin
      e = '0;
      e.halted = m_halted;
    end else if (en && !m_halted) begin
      e = captured();
      m_halted = m_halted | halt_i;
    end
    model = e;
    sbq.push_back(e);
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    outs_t got, exp;
    nRST = 1'b0; en = 1'b0; flush = 1'b0;
    rand_inputs();
    model = '0; m_halted = 1'b0;
    #3;
    sbq.push_back('0);
    got = actual(); exp = sbq.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL reset_state: got=%h exp=%h", got, exp);
    end
    @(negedge CLK); nRST = 1'b1;
  endtask

  task automatic test_capture();
    outs_t got, exp;
    en = 1'b1; flush = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      rand_inputs();
      if (i == 0) begin imm_i = 16'h8001; ExtOp_i = 1'b1; rdat1_i = 32'hDEADBEEF; end
      if (i == 1) begin imm_i = 16'h8001; ExtOp_i = 1'b0; rdat1_i = 32'hDEADBEEF; end
      if (i == 2) begin imm_i = 16'h7FFF; ExtOp_i = 1'b1; end
      step();
      got = actual(); exp = sbq.pop_front(); checks++;
      if (got !== exp) begin
        failures++; $display("FAIL capture[%0d]: got=%h exp=%h", i, got, exp);
      end
      if (i == 0) begin
        checks++;
        if (imm32_o !== 32'hFFFF8001 || rdat1_o !== 32'hDEADBEEF || valid_o !== 1'b1) begin
          failures++;
          $display("FAIL sign_ext: imm32=%h rdat1=%h valid=%b exp FFFF8001 DEADBEEF 1", imm32_o, rdat1_o, valid_o);
        end
      end
      if (i == 1) begin
        checks++;
        if (imm32_o !== 32'h00008001) begin
          failures++; $display("FAIL zero_ext: imm32=%h exp=00008001", imm32_o);
        end
      end
    end
  endtask

  task automatic test_stall();
    outs_t got, exp;
    en = 1'b1; flush = 1'b0;
    rand_inputs(); dmemREN_i = 1'b1; dmemWEN_i = 1'b0;
    step();
    got = actual(); exp = sbq.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL stall_load: got=%h exp=%h", got, exp);
    end
    en = 1'b0;
    for (int unsigned i = 0; i < 3; i++) begin
      rand_inputs(); halt_i = 1'($urandom); dmemREN_i = 1'b0;
      step();
      got = actual(); exp = sbq.pop_front(); checks++;
      if (got !== exp || dmemREN_o !== 1'b1) begin
        failures++; $display("FAIL stall_hold[%0d]: got=%h exp=%h dmemREN=%b", i, got, exp, dmemREN_o);
      end
    end
  endtask

  task automatic test_flush();
    outs_t got, exp;
    for (int unsigned i = 0; i < 2; i++) begin
      en = 1'b1; flush = 1'b0;
      rand_inputs(); RegWEN_i = 1'b1; dmemWEN_i = 1'b1; tmpPC_i = 2'b11; branch_i = 1'b1;
      step();
      got = actual(); exp = sbq.pop_front(); checks++;
      if (got !== exp) begin
        failures++; $display("FAIL flush_setup[%0d]: got=%h exp=%h", i, got, exp);
      end
      en = (i == 1); flush = 1'b1;
      rand_inputs();
      step();
      got = actual(); exp = sbq.pop_front(); checks++;
      if (got !== exp || RegWEN_o !== 1'b0 || dmemWEN_o !== 1'b0 || valid_o !== 1'b0 || tmpPC_o !== 2'b00) begin
        failures++; $display("FAIL flush_bubble[%0d]: got=%h exp=%h", i, got, exp);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    outs_t got, exp;
    for (int unsigned i = 0; i < 24; i++) begin
      rand_inputs();
      en = 1'($urandom); flush = ($urandom_range(0, 3) == 0);
      step();
      got = actual(); exp = sbq.pop_front(); checks++;
      if (got !== exp) begin
        failures++; $display("FAIL b2b[%0d]: got=%h exp=%h", i, got, exp);
      end
    end
    flush = 1'b0;
  endtask

  task automatic test_halt();
    outs_t got, exp;
    en = 1'b1; flush = 1'b0;
    rand_inputs(); halt_i = 1'b1;
    step();
    got = actual(); exp = sbq.pop_front(); checks++;
    if (got !== exp || halted_o !== 1'b1 || halt_o !== 1'b1) begin
      failures++; $display("FAIL halt_capture: got=%h exp=%h", got, exp);
    end
    for (int unsigned i = 0; i < 5; i++) begin
      rand_inputs(); halt_i = 1'($urandom);
      step();
      got = actual(); exp = sbq.pop_front(); checks++;
      if (got !== exp || halt_o !== 1'b1) begin
        failures++; $display("FAIL halt_frozen[%0d]: got=%h exp=%h", i, got, exp);
      end
    end
    flush = 1'b1;
    step();
    got = actual(); exp = sbq.pop_front(); checks++;
    if (got !== exp || halted_o !== 1'b1 || valid_o !== 1'b0) begin
      failures++; $display("FAIL halt_flush: got=%h exp=%h", got, exp);
    end
    flush = 1'b0; rand_inputs();
    step();
    got = actual(); exp = sbq.pop_front(); checks++;
    if (got !== exp || valid_o !== 1'b0) begin
      failures++; $display("FAIL halt_after_flush: got=%h exp=%h", got, exp);
    end
    nRST = 1'b0;
    #2;
    model = '0; m_halted = 1'b0;
    sbq.push_back('0);
    got = actual(); exp = sbq.pop_front(); checks++;
    if (got !== exp) begin
      failures++; $display("FAIL midcycle_reset: got=%h exp=%h", got, exp);
    end
    @(negedge CLK); nRST = 1'b1;
  endtask

`ifdef ID_EX_TRACE_EN
  task automatic test_trace();
    outs_t got, exp;
    en = 1'b1; flush = 1'b0;
    rand_inputs(); pc_i = 32'h0000_0040;
    step();
    got = actual(); exp = sbq.pop_front(); checks++;
    if (got !== exp || pc_o !== 32'h40) begin
      failures++; $display("FAIL trace_pc: got=%h exp=%h", pc_o, 32'h40);
    end
    flush = 1'b1;
    step();
    got = actual(); exp = sbq.pop_front(); checks++;
    if (got !== exp || pc_o !== 32'h0 || instr_o !== 32'h0) begin
      failures++; $display("FAIL trace_flush: pc=%h instr=%h exp 0", pc_o, instr_o);
    end
    flush = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_capture();
    test_stall();
    test_flush();
    test_back_to_back();
    test_halt();
    test_capture();
`ifdef ID_EX_TRACE_EN
    test_trace();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_ex_latch.md
Name: id_ex_latch

Overview:
- Decode-to-execute pipeline register, directly downstream of the control unit.
- Captures the control unit's decoded control word together with register-file read data, register specifiers and the immediate.
- Presents all of these, registered, to the execute stage.
- Handles stall (hold), flush (bubble insertion), immediate extension at capture, and a sticky halt.

Parameters:
- WORD_W, 32, datapath word width.
- IMM_W, 16, raw immediate width.

Ports:
- CLK  in  1  system clock.
- nRST  in  1  asynchronous active-low reset.
- en  in  1  advance pipeline (high when the stage may capture).
- flush  in  1  replace captured contents with a bubble.
- RegWEN_i, ALUSrc_i, ExtOp_i, dmemREN_i, dmemWEN_i, halt_i, branch_i  in  1 each  control unit outputs.
- tmpPC_i, RegDest_i, MemtoReg_i  in  2 each  control unit outputs.
- ALUOP_i  in  aluop_t(4)  ALU operation.
- rdat1_i, rdat2_i  in  WORD_W  register-file read data.
- imm_i  in  IMM_W  instruction immediate field.
- rs_i, rt_i, rd_i, shamt_i  in  5 each  instruction fields.
- npc_i  in  WORD_W  PC+4 of the instruction.
- jaddr_i  in  26  jump target field.
- all *_o counterparts of the above except ExtOp and imm  out  same widths.
- imm32_o  out  WORD_W  extended immediate.
- valid_o  out  1  slot holds a real instruction.
- halted_o  out  1  sticky halt seen.

Behaviour:
- Reset (nRST low, asynchronous): every output is 0, including valid_o, halted_o and ALUOP_o (ALU_SLL encoding 0).
- Capture: on posedge CLK with en=1 and flush=0, all *_o take their *_i values on the next edge and valid_o=1. Latency is one cycle.
- Immediate extension at capture:
  - ExtOp_i=1: imm32 = sign-extend(imm_i), replicating bit 15.
  - ExtOp_i=0: imm32 = zero-extend(imm_i).
- Hold: en=0 and flush=0 keeps every register unchanged. A stall must not re-issue a memory request twice; downstream relies on valid_o.
- Flush: flush=1 on the edge overrides en, so flush with en=0 still flushes. The result is a bubble:
  - RegWEN_o, dmemREN_o, dmemWEN_o, branch_o, halt_o, valid_o are 0.
  - tmpPC_o = 0 (sequential).
  - Datapath fields are don't-care but are cleared to 0 for determinism.
- Sticky halt:
  - When a valid halt is captured (en=1, flush=0, halt_i=1), halted_o sets and stays set until reset.
  - While halted_o=1, further captures are suppressed: the register holds even if en=1. Flush still clears everything except halted_o.
- halt_o stays 1 while held, so the execute stage sees a stable halt.
- Reset mid-operation clears all state immediately, independent of CLK.

Optional Feature:
- Macro: ID_EX_TRACE_EN.
- Defined:
  - Extra ports instr_i/instr_o (WORD_W) and pc_i/pc_o (WORD_W) are latched with the same en/flush/halt rules.
  - instr_o and pc_o are cleared on bubble. They are used by the trace/checker logic.
- Undefined: the ports are absent and there is no extra logic.

Decomposition:
- cpu_types_pkg gains:
  - typedef struct packed id_ex_ctrl_t grouping RegWEN, ALUSrc, dmemREN, dmemWEN, halt, branch, tmpPC, RegDest, MemtoReg, ALUOP.
  - constant ID_EX_BUBBLE of type id_ex_ctrl_t.
- aluop_t and word_t are reused from cpu_types_pkg.
- One sub-module, imm_ext: combinational sign/zero extender (IMM_W to WORD_W, ExtOp select). It is reusable by the single-cycle datapath.

Test Plan:
- Reset: assert nRST=0 mid-cycle -> all outputs 0 immediately; valid_o=0, halted_o=0.
- Capture: en=1, imm_i=16'h8001, ExtOp_i=1, rdat1_i=32'hDEADBEEF -> next edge imm32_o=32'hFFFF8001, rdat1_o=32'hDEADBEEF, valid_o=1. Repeat with ExtOp_i=0 -> imm32_o=32'h00008001.
- Stall: capture a load (dmemREN_i=1), then en=0 for 3 cycles while inputs toggle -> outputs unchanged, dmemREN_o=1 throughout.
- Flush priority: en=0, flush=1 with RegWEN_o=1 held -> next edge RegWEN_o=0, dmemWEN_o=0, valid_o=0, tmpPC_o=2'b00.
- Halt: capture halt_i=1 -> halted_o=1, halt_o=1. Then en=1 with new instructions for 5 cycles -> outputs frozen. Then flush -> halted_o still 1.
- Trace (ID_EX_TRACE_EN defined): pc_i=32'h0000_0040 captured -> pc_o=32'h40; flush -> pc_o=0.
